// File: rtl/fifo_wr_arbiter_if.sv
// Handshake and FIFO write-side bundle for fifo_wr_arbiter.
// master: the environment side (requesters and FIFO flags).
// slave:  the arbiter side (accepts beats, drives the FIFO write port).
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         fifo_din;
    logic                      fifo_wr_en;
    logic                      fifo_full;
    logic                      fifo_almost_full;

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        output fifo_almost_full,
        input  req_ready,
        input  fifo_din,
        input  fifo_wr_en
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        input  fifo_almost_full,
        output req_ready,
        output fifo_din,
        output fifo_wr_en
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ
// requesters in the wr_clk domain. Each grant allows a burst of up to
// BURST_MAX beats; beats are only accepted while the FIFO reports at least
// two free entries, so the one in-flight registered write always fits.
// A one-cycle IDLE bubble separates consecutive grants.
//
// Optional feature macro: WR_ARB_STAT_EN
//   adds beat_total (per-requester saturating 16-bit accepted-beat counters)
//   and stall_err (sticky: fifo_full seen while fifo_wr_en is high).
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    fifo_wr_arbiter_if.slave      bus,
    output logic                  busy
`ifdef WR_ARB_STAT_EN
    ,
    output logic [NUM_REQ*16-1:0] beat_total,
    output logic                  stall_err
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [CNT_W-1:0]   beat_cnt;
    logic               wr_en_q;
    logic [DATA_W-1:0]  din_q;

    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   scan_cand;
    logic               scan_hit;
    logic               flags_ok;
    logic               in_burst;
    logic               grant_valid;
    logic               accept;
    logic               burst_done;
    logic [PTR_W-1:0]   next_rr;
    logic [NUM_REQ-1:0] ready_vec;
    logic [DATA_W-1:0]  sel_data;

    // Pick the first valid requester starting from rr_ptr and wrapping around.
    always_comb begin
        scan_idx  = rr_ptr;
        scan_cand = rr_ptr;
        scan_hit  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!scan_hit && bus.req_valid[scan_cand]) begin
                scan_hit = 1'b1;
                scan_idx = scan_cand;
            end
        end
    end

    // Ready is offered only to the granted requester, and only while the FIFO has room for two more.
    always_comb begin
        flags_ok    = !bus.fifo_almost_full && !bus.fifo_full;
        in_burst    = (state == BURST);
        grant_valid = bus.req_valid[grant_idx];
        accept      = in_burst && flags_ok && grant_valid;
        burst_done  = (accept && (beat_cnt == LAST_BEAT)) || !grant_valid;
        next_rr     = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        ready_vec   = '0;
        sel_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                ready_vec[i] = in_burst && flags_ok;
                sel_data     = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.fifo_din   = din_q;
    assign busy           = (state == BURST);

    // Arbitration FSM plus the one-cycle registered FIFO write stage.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            wr_en_q   <= 1'b0;
            din_q     <= '0;
        end else begin
            wr_en_q <= accept;
            if (accept) begin
                din_q <= sel_data;
            end
            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        grant_idx <= scan_idx;
                        beat_cnt  <= '0;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (burst_done) begin
                        rr_ptr <= next_rr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WR_ARB_STAT_EN
    // Per-requester accepted-beat counters (saturating) and the sticky write-while-full flag.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_total <= '0;
            stall_err  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && (grant_idx == PTR_W'(i)) && (beat_total[i*16 +: 16] != 16'hFFFF)) begin
                    beat_total[i*16 +: 16] <= beat_total[i*16 +: 16] + 16'd1;
                end
            end
            if (bus.fifo_full && wr_en_q) begin
                stall_err <= 1'b1;
            end
        end
    end
`endif

endmodule
